// File: rtl/connect4_pkg.sv
// Shared constants, FSM encoding and winner codes for the Connect4 move path.
package connect4_pkg;

  localparam int         NUM_COLS = 4;
  localparam logic [2:0] COL_NONE = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLACE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/win_checker.sv
// Combinational four-in-a-row detector for one player's occupancy map.
// Map bit (c*ROWS + r) is column c, row r (row 0 at the bottom).
module win_checker
  import connect4_pkg::*;
#(
  parameter int ROWS = 4
) (
  input  logic [NUM_COLS*ROWS-1:0] i_map,
  output logic                     o_win
);

  always_comb begin
    o_win = 1'b0;
    // With four columns, a horizontal line is always a complete row.
    for (int r = 0; r < ROWS; r++) begin
      if (i_map[r] && i_map[ROWS+r] && i_map[2*ROWS+r] && i_map[3*ROWS+r])
        o_win = 1'b1;
    end
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r <= ROWS - 4; r++) begin
        if (i_map[c*ROWS+r] && i_map[c*ROWS+r+1] &&
            i_map[c*ROWS+r+2] && i_map[c*ROWS+r+3])
          o_win = 1'b1;
      end
    end
    for (int r = 0; r <= ROWS - 4; r++) begin
      if (i_map[r] && i_map[ROWS+r+1] && i_map[2*ROWS+r+2] && i_map[3*ROWS+r+3])
        o_win = 1'b1;
      if (i_map[r+3] && i_map[ROWS+r+2] && i_map[2*ROWS+r+1] && i_map[3*ROWS+r])
        o_win = 1'b1;
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Connect4 turn/placement controller: validates moves, writes one cell per move, detects game end.
// Four-in-a-row detection is compiled only when WIN_DETECT_EN is defined; otherwise only a full board ends the game.
//
// state   | meaning
// S_IDLE  | waiting for a move strobe; refuses no-column or full-column requests
// S_PLACE | board write cycle; height and occupancy map update at its end
// S_CHECK | evaluate win/draw on the updated map, else hand the turn over
// S_DONE  | game finished; only new_game leaves
module move_sequencer
  import connect4_pkg::*;
#(
  parameter int ROWS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    new_game,
  input  logic                    move_valid,
  input  logic [2:0]              column_decode,
  output logic                    busy,
  output logic                    move_reject,
  output logic                    wr_en,
  output logic [1:0]              wr_col,
  output logic [$clog2(ROWS)-1:0] wr_row,
  output logic                    wr_player,
  output logic                    current_player,
  output logic [NUM_COLS-1:0]     column_full,
  output logic                    game_over,
  output logic [1:0]              winner
);

  localparam int RW = $clog2(ROWS);
  localparam int HW = $clog2(ROWS + 1);
  localparam int CW = $clog2(NUM_COLS * ROWS);

  seq_state_t              r_state;
  logic [HW-1:0]           r_height [NUM_COLS];
  logic [NUM_COLS*ROWS-1:0] r_p0_map;
  logic [NUM_COLS*ROWS-1:0] r_p1_map;
  logic                    r_player;
  logic [1:0]              r_col;
  logic [RW-1:0]           r_wr_row;
  logic                    r_wr_player;
  logic                    r_wr_en;
  logic                    r_move_reject;
  logic                    r_game_over;
  logic [1:0]              r_winner;

  logic                    w_bad_move;
  logic                    w_win;
  logic [CW-1:0]           w_cell;

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_full
    assign column_full[c] = (r_height[c] == HW'(ROWS));
  end

  assign w_bad_move = (column_decode == COL_NONE) || column_decode[2] ||
                      column_full[column_decode[1:0]];
  assign w_cell     = CW'(r_col) * CW'(ROWS) + CW'(r_wr_row);

`ifdef WIN_DETECT_EN
  logic [NUM_COLS*ROWS-1:0] w_cur_map;
  assign w_cur_map = r_player ? r_p1_map : r_p0_map;

  win_checker #(.ROWS(ROWS)) u_win_checker (
    .i_map (w_cur_map),
    .o_win (w_win)
  );
`else
  // Maps are kept as board state even though nothing here inspects them.
  logic w_unused_maps;
  assign w_unused_maps = ^{r_p0_map, r_p1_map};
  assign w_win         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      for (int c = 0; c < NUM_COLS; c++) r_height[c] <= '0;
      r_p0_map      <= '0;
      r_p1_map      <= '0;
      r_player      <= 1'b0;
      r_col         <= '0;
      r_wr_row      <= '0;
      r_wr_player   <= 1'b0;
      r_wr_en       <= 1'b0;
      r_move_reject <= 1'b0;
      r_game_over   <= 1'b0;
      r_winner      <= WIN_NONE;
    end else if (new_game) begin
      r_state       <= S_IDLE;
      for (int c = 0; c < NUM_COLS; c++) r_height[c] <= '0;
      r_p0_map      <= '0;
      r_p1_map      <= '0;
      r_player      <= 1'b0;
      r_wr_en       <= 1'b0;
      r_move_reject <= 1'b0;
      r_game_over   <= 1'b0;
      r_winner      <= WIN_NONE;
    end else begin
      r_move_reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (move_valid) begin
            if (w_bad_move) begin
              r_move_reject <= 1'b1;
            end else begin
              r_col       <= column_decode[1:0];
              r_wr_row    <= r_height[column_decode[1:0]][RW-1:0];
              r_wr_player <= r_player;
              r_wr_en     <= 1'b1;
              r_state     <= S_PLACE;
            end
          end
        end
        S_PLACE: begin
          r_wr_en         <= 1'b0;
          r_height[r_col] <= r_height[r_col] + 1'b1;
          if (r_player) r_p1_map[w_cell] <= 1'b1;
          else          r_p0_map[w_cell] <= 1'b1;
          r_state         <= S_CHECK;
        end
        S_CHECK: begin
          if (w_win) begin
            r_winner    <= r_player ? WIN_P1 : WIN_P0;
            r_game_over <= 1'b1;
            r_state     <= S_DONE;
          end else if (&column_full) begin
            r_winner    <= WIN_DRAW;
            r_game_over <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_player    <= ~r_player;
            r_state     <= S_IDLE;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign move_reject    = r_move_reject;
  assign wr_en          = r_wr_en;
  assign wr_col         = r_col;
  assign wr_row         = r_wr_row;
  assign wr_player      = r_wr_player;
  assign current_player = r_player;
  assign game_over      = r_game_over;
  assign winner         = r_winner;

endmodule
